// File: rtl/inst_len_dec_pkg.sv
// inst_pkg: addressing-mode classes, cycle counts and sequencer width shared
// by the instruction length decoder, its opcode ROM and the bus interface.
package inst_pkg;

    // Width of the sequencer's one-hot cycle vector (T0..T5).
    localparam int CYC_W = 6;

    // Addressing-mode class of an opcode. There are 18 classes, so the
    // encoding needs 5 bits.
    typedef enum logic [4:0] {
        MODE_IMPL,
        MODE_IMM,
        MODE_ZP,
        MODE_ZPX,
        MODE_ABS,
        MODE_ABSX_RD,
        MODE_ABSX_WR,
        MODE_INDX,
        MODE_INDY_RD,
        MODE_INDY_WR,
        MODE_RMW_ZP,
        MODE_RMW_ZPX,
        MODE_RMW_ABS,
        MODE_RMW_ABSX,
        MODE_STACK,
        MODE_BRANCH,
        MODE_JMP,
        MODE_ILL
    } mode_t;

    // Base cycle counts. STACK and JMP hold several opcodes with different
    // lengths, so those lengths are listed per opcode.
    localparam logic [2:0] LEN_IMPL     = 3'd2;
    localparam logic [2:0] LEN_IMM      = 3'd2;
    localparam logic [2:0] LEN_ZP       = 3'd3;
    localparam logic [2:0] LEN_ZPX      = 3'd4;
    localparam logic [2:0] LEN_ABS      = 3'd4;
    localparam logic [2:0] LEN_ABSX_RD  = 3'd4;
    localparam logic [2:0] LEN_ABSX_WR  = 3'd5;
    localparam logic [2:0] LEN_INDX     = 3'd6;
    localparam logic [2:0] LEN_INDY_RD  = 3'd5;
    localparam logic [2:0] LEN_INDY_WR  = 3'd6;
    localparam logic [2:0] LEN_RMW_ZP   = 3'd5;
    localparam logic [2:0] LEN_RMW_ZPX  = 3'd6;
    localparam logic [2:0] LEN_RMW_ABS  = 3'd6;
    localparam logic [2:0] LEN_RMW_ABSX = 3'd7;
    localparam logic [2:0] LEN_BRANCH   = 3'd2;
    localparam logic [2:0] LEN_PUSH     = 3'd3;
    localparam logic [2:0] LEN_PULL     = 3'd4;
    localparam logic [2:0] LEN_JSR      = 3'd6;
    localparam logic [2:0] LEN_RTS      = 3'd6;
    localparam logic [2:0] LEN_RTI      = 3'd6;
    localparam logic [2:0] LEN_BRK      = 3'd7;
    localparam logic [2:0] LEN_JMP_ABS  = 3'd3;
    localparam logic [2:0] LEN_JMP_IND  = 3'd5;

    // Length of the classes whose length does not depend on the opcode.
    function automatic logic [2:0] mode_len(input mode_t m);
        case (m)
            MODE_IMM:      return LEN_IMM;
            MODE_ZP:       return LEN_ZP;
            MODE_ZPX:      return LEN_ZPX;
            MODE_ABS:      return LEN_ABS;
            MODE_ABSX_RD:  return LEN_ABSX_RD;
            MODE_ABSX_WR:  return LEN_ABSX_WR;
            MODE_INDX:     return LEN_INDX;
            MODE_INDY_RD:  return LEN_INDY_RD;
            MODE_INDY_WR:  return LEN_INDY_WR;
            MODE_RMW_ZP:   return LEN_RMW_ZP;
            MODE_RMW_ZPX:  return LEN_RMW_ZPX;
            MODE_RMW_ABS:  return LEN_RMW_ABS;
            MODE_RMW_ABSX: return LEN_RMW_ABSX;
            MODE_BRANCH:   return LEN_BRANCH;
            default:       return LEN_IMPL;
        endcase
    endfunction

endpackage

// File: rtl/inst_len_dec_if.sv
// Sequencer/bus <-> instruction length decoder interface.
// Handshake: the sequencer presents a one-hot cycle each clock with sync=1 at
// T0. The decoder raises next_sync combinationally in the last cycle of the
// instruction, and the sequencer returns to T0 on the following edge. There
// is no back-pressure; every cycle is consumed.
interface inst_len_dec_if #(
    parameter int CYC_W = inst_pkg::CYC_W
);
    logic [CYC_W-1:0]    cycle;
    logic                sync;
    logic [7:0]          data_in;
    logic                page_cross;
    logic                branch_taken;
    logic                next_sync;
    logic [7:0]          ir;
    inst_pkg::mode_t     mode;
    logic                illegal;

    // Sequencer / fetch side.
    modport master (
        output cycle, sync, data_in, page_cross, branch_taken,
        input  next_sync, ir, mode, illegal
    );

    // Decoder side.
    modport slave (
        input  cycle, sync, data_in, page_cross, branch_taken,
        output next_sync, ir, mode, illegal
    );
endinterface

// File: rtl/inst_len_dec_rom.sv
// inst_len_rom: combinational opcode -> {mode, base_len, is_illegal} table.
// Optional build macro INST_ILLEGAL_TRAP_EN: undocumented opcodes decode as
// MODE_ILL with is_illegal=1. Otherwise they decode as a 2-cycle implied NOP
// with is_illegal=0.
module inst_len_rom
    import inst_pkg::*;
(
    input  logic [7:0] opcode,
    output mode_t      mode,
    output logic [2:0] base_len,
    output logic       is_illegal
);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic       rmw;
    logic       doc;
    mode_t      cls;
    logic [2:0] fixed_len;

    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];
    // In the cc=10 group, aaa=100/101 are STX/LDX; the rest are shifts/INC/DEC.
    assign rmw = (aaa[2:1] != 2'b10);

    // Classify the opcode by its aaabbbcc fields and flag documented ones.
    always_comb begin
        cls       = MODE_IMPL;
        doc       = 1'b0;
        fixed_len = LEN_IMPL;
        case (cc)
            2'b01: begin
                doc = 1'b1;
                case (bbb)
                    3'b000:  cls = MODE_INDX;
                    3'b001:  cls = MODE_ZP;
                    3'b010:  begin cls = MODE_IMM; doc = (aaa != 3'b100); end
                    3'b011:  cls = MODE_ABS;
                    3'b100:  cls = (aaa == 3'b100) ? MODE_INDY_WR : MODE_INDY_RD;
                    3'b101:  cls = MODE_ZPX;
                    default: cls = (aaa == 3'b100) ? MODE_ABSX_WR : MODE_ABSX_RD;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'b000:  begin cls = MODE_IMM; doc = (aaa == 3'b101); end
                    3'b001:  begin cls = rmw ? MODE_RMW_ZP : MODE_ZP; doc = 1'b1; end
                    3'b010:  begin cls = MODE_IMPL; doc = 1'b1; end
                    3'b011:  begin cls = rmw ? MODE_RMW_ABS : MODE_ABS; doc = 1'b1; end
                    3'b101:  begin cls = rmw ? MODE_RMW_ZPX : MODE_ZPX; doc = 1'b1; end
                    3'b110:  begin cls = MODE_IMPL; doc = !rmw; end
                    3'b111:  begin cls = rmw ? MODE_RMW_ABSX : MODE_ABSX_RD; doc = (aaa != 3'b100); end
                    default: doc = 1'b0;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'b000: begin
                        doc = 1'b1;
                        cls = MODE_STACK;
                        case (aaa)
                            3'b000:  fixed_len = LEN_BRK;
                            3'b001:  fixed_len = LEN_JSR;
                            3'b010:  fixed_len = LEN_RTI;
                            3'b011:  fixed_len = LEN_RTS;
                            3'b100:  doc = 1'b0;
                            default: cls = MODE_IMM;
                        endcase
                    end
                    3'b001:  begin cls = MODE_ZP; doc = (aaa == 3'b001) || aaa[2]; end
                    3'b010: begin
                        doc = 1'b1;
                        if (aaa[2]) begin
                            cls = MODE_IMPL;
                        end else begin
                            cls       = MODE_STACK;
                            fixed_len = aaa[0] ? LEN_PULL : LEN_PUSH;
                        end
                    end
                    3'b011: begin
                        doc = 1'b1;
                        cls = MODE_ABS;
                        case (aaa)
                            3'b000:  doc = 1'b0;
                            3'b010:  begin cls = MODE_JMP; fixed_len = LEN_JMP_ABS; end
                            3'b011:  begin cls = MODE_JMP; fixed_len = LEN_JMP_IND; end
                            default: cls = MODE_ABS;
                        endcase
                    end
                    3'b100:  begin cls = MODE_BRANCH; doc = 1'b1; end
                    3'b101:  begin cls = MODE_ZPX; doc = (aaa[2:1] == 2'b10); end
                    3'b110:  begin cls = MODE_IMPL; doc = 1'b1; end
                    default: begin cls = MODE_ABSX_RD; doc = (aaa == 3'b101); end
                endcase
            end
            default: doc = 1'b0;
        endcase
    end

    // Resolve the final class and length, folding in undocumented opcodes.
    always_comb begin
        mode       = cls;
        base_len   = (cls == MODE_STACK || cls == MODE_JMP) ? fixed_len : mode_len(cls);
        is_illegal = 1'b0;
        if (!doc) begin
            base_len = LEN_IMPL;
`ifdef INST_ILLEGAL_TRAP_EN
            mode       = MODE_ILL;
            is_illegal = 1'b1;
`else
            mode       = MODE_IMPL;
            is_illegal = 1'b0;
`endif
        end
    end
endmodule

// File: rtl/inst_len_dec.sv
// inst_len_dec: latches the opcode at sync, tracks the instruction's length
// (including page-cross and taken-branch extensions) and raises next_sync in
// its final cycle so the one-hot sequencer restarts at T0.
// Optional build macro INST_ILLEGAL_TRAP_EN (handled in inst_len_rom) makes
// undocumented opcodes raise illegal for the duration of the instruction.
module inst_len_dec
    import inst_pkg::*;
#(
    parameter int         CYC_W      = inst_pkg::CYC_W,
    parameter logic [7:0] RST_OPCODE = 8'hEA
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_len_dec_if.slave bus
);
    logic       start;
    logic [7:0] ir_q;
    mode_t      mode_q;
    logic [2:0] base_len;
    logic [1:0] extra;
    logic       illegal_q;

    logic [7:0] rom_op;
    mode_t      dec_mode;
    logic [2:0] dec_len;
    logic       dec_ill;

    logic [2:0] idx;
    logic [3:0] eff_len;
    logic       would_end;
    logic       ext;
    logic [1:0] extra_nxt;
    logic       watchdog;

    // During the sync cycle the ROM sees the bus, so 2-cycle opcodes can end at T1.
    assign rom_op = bus.sync ? bus.data_in : ir_q;

    inst_len_rom u_rom (
        .opcode     (rom_op),
        .mode       (dec_mode),
        .base_len   (dec_len),
        .is_illegal (dec_ill)
    );

    // Position of the lowest set cycle bit; an all-zero vector is T6.
    always_comb begin
        idx = 3'(CYC_W);
        for (int i = CYC_W - 1; i >= 0; i--) begin
            if (bus.cycle[i]) idx = 3'(i);
        end
    end

    assign eff_len   = bus.sync ? {1'b0, dec_len} : ({1'b0, base_len} + {2'b00, extra});
    assign would_end = ({1'b0, idx} == (eff_len - 4'd1));

    // Decide whether the would-be last cycle is stretched by one more cycle.
    always_comb begin
        ext       = 1'b0;
        extra_nxt = extra;
        if (!bus.sync && would_end) begin
            case (mode_q)
                MODE_ABSX_RD, MODE_INDY_RD: begin
                    if (bus.page_cross && extra == 2'd0) begin
                        ext       = 1'b1;
                        extra_nxt = 2'd1;
                    end
                end
                MODE_BRANCH: begin
                    if (idx == 3'd1 && extra == 2'd0 && bus.branch_taken) begin
                        ext       = 1'b1;
                        extra_nxt = 2'd1;
                    end else if (idx == 3'd2 && extra == 2'd1 && bus.page_cross) begin
                        ext       = 1'b1;
                        extra_nxt = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // The sequencer ran past T5 on an instruction shorter than 7 cycles.
    // Not armed during start-up, when the sequencer has not yet been synced.
    assign watchdog = !start && (bus.cycle == '0) && (eff_len < 4'd7);

    assign bus.next_sync = start | watchdog | (would_end & ~ext);
    assign bus.ir        = ir_q;
    assign bus.mode      = mode_q;
    assign bus.illegal   = illegal_q;

    // Opcode latch, extension count and illegal flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start     <= 1'b1;
            ir_q      <= RST_OPCODE;
            mode_q    <= MODE_IMPL;
            base_len  <= LEN_IMPL;
            extra     <= 2'd0;
            illegal_q <= 1'b0;
        end else begin
            start <= 1'b0;
            if (bus.sync) begin
                ir_q      <= bus.data_in;
                mode_q    <= dec_mode;
                base_len  <= dec_len;
                extra     <= 2'd0;
                illegal_q <= dec_ill | watchdog;
            end else begin
                extra <= extra_nxt;
                if (watchdog) illegal_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_len_dec.sv
// Self-checking bench for inst_len_dec. Honours INST_ILLEGAL_TRAP_EN when
// the build defines it.
module tb_inst_len_dec;
    import inst_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    inst_len_dec_if #(.CYC_W(6)) bus ();

    inst_len_dec #(.CYC_W(6), .RST_OPCODE(8'hEA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: documented opcodes listed by instruction length (0 = undocumented).
    function automatic int ref_base(input logic [7:0] op);
        case (op)
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9, 8'hA2, 8'hA0, 8'hC0, 8'hE0,
            8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'h8A, 8'hAA, 8'hCA, 8'hEA, 8'h9A, 8'hBA,
            8'h88, 8'hA8, 8'hC8, 8'hE8, 8'h18, 8'h38, 8'h58, 8'h78, 8'h98, 8'hB8,
            8'hD8, 8'hF8, 8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: return 2;
            8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5, 8'h86, 8'hA6,
            8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4, 8'h08, 8'h48, 8'h4C: return 3;
            8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5, 8'h96, 8'hB6,
            8'h94, 8'hB4, 8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
            8'h8E, 8'hAE, 8'h2C, 8'h8C, 8'hAC, 8'hCC, 8'hEC,
            8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'hBD, 8'hDD, 8'hFD,
            8'h19, 8'h39, 8'h59, 8'h79, 8'hB9, 8'hD9, 8'hF9, 8'hBE, 8'hBC,
            8'h28, 8'h68: return 4;
            8'h11, 8'h31, 8'h51, 8'h71, 8'hB1, 8'hD1, 8'hF1, 8'h9D, 8'h99,
            8'h06, 8'h26, 8'h46, 8'h66, 8'hC6, 8'hE6, 8'h6C: return 5;
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1, 8'h91,
            8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6,
            8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'hCE, 8'hEE, 8'h20, 8'h60, 8'h40: return 6;
            8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'h00: return 7;
            default: return 0;
        endcase
    endfunction

    // Indexed reads that take one more cycle on a page crossing.
    function automatic bit ref_idx_rd(input logic [7:0] op);
        case (op)
            8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'hBD, 8'hDD, 8'hFD,
            8'h19, 8'h39, 8'h59, 8'h79, 8'hB9, 8'hD9, 8'hF9, 8'hBE, 8'hBC,
            8'h11, 8'h31, 8'h51, 8'h71, 8'hB1, 8'hD1, 8'hF1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_branch(input logic [7:0] op);
        case (op)
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Total cycles given the page_cross and branch_taken values per cycle.
    function automatic int ref_cycles(input logic [7:0] op, input logic [7:0] pcv, input logic [7:0] btv);
        int n;
        n = ref_base(op);
        if (n == 0) n = 2;
        if (ref_idx_rd(op) && pcv[n-1]) n = n + 1;
        if (ref_branch(op) && btv[1]) begin
            n = 3;
            if (pcv[2]) n = 4;
        end
        return n;
    endfunction

    function automatic bit ref_illegal(input logic [7:0] op);
`ifdef INST_ILLEGAL_TRAP_EN
        return (ref_base(op) == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Drive the sequencer-side inputs for cycle t of an instruction.
    task automatic drive_cycle(input int t, input logic [7:0] op, input logic pc, input logic bt);
        bus.sync         = (t == 0);
        bus.cycle        = '0;
        if (t < 6) bus.cycle[t] = 1'b1;
        bus.data_in      = (t == 0) ? op : 8'($urandom);
        bus.page_cross   = pc;
        bus.branch_taken = bt;
    endtask

    // Run one instruction from T0 following the reference sequencer; checks
    // next_sync every cycle and ir/illegal after the opcode has latched.
    task automatic run_inst(input logic [7:0] op, input logic [7:0] pcv, input logic [7:0] btv);
        int n;
        n = ref_cycles(op, pcv, btv);
        for (int t = 0; t < n; t++) begin
            drive_cycle(t, op, pcv[t], btv[t]);
            @(negedge clk);
            check($sformatf("next_sync op=%02h t=%0d", op, t), 32'(bus.next_sync), 32'(t == n - 1));
            if (t >= 1) begin
                check($sformatf("ir op=%02h", op), 32'(bus.ir), 32'(op));
                check($sformatf("illegal op=%02h", op), 32'(bus.illegal), 32'(ref_illegal(op)));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle();
        bus.sync         = 1'b0;
        bus.cycle        = 6'b000001;
        bus.data_in      = 8'h00;
        bus.page_cross   = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_cycle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset next_sync", 32'(bus.next_sync), 32'd1);
        check("reset ir", 32'(bus.ir), 32'h0EA);
        check("reset mode", 32'(bus.mode), 32'(MODE_IMPL));
        check("reset illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;

        // Immediate load: ends at T1.
        run_inst(8'hA9, 8'hFF, 8'hFF);
        check("mode A9", 32'(bus.mode), 32'(MODE_IMM));

        // Indexed read with and without a page crossing.
        run_inst(8'hBD, 8'b0000_1000, 8'h00);
        run_inst(8'hBD, 8'h00, 8'h00);
        // Taken branch across a page, taken in page, not taken.
        run_inst(8'hD0, 8'b0000_0100, 8'b0000_0010);
        run_inst(8'hD0, 8'h00, 8'b0000_0010);
        run_inst(8'hD0, 8'hFF, 8'h00);
        // RMW abs,X ends at T6 and ignores page_cross; store never extends.
        run_inst(8'hFE, 8'hFF, 8'h00);
        check("mode FE", 32'(bus.mode), 32'(MODE_RMW_ABSX));
        run_inst(8'h9D, 8'hFF, 8'h00);
        // Undocumented opcode: 2 cycles, illegal only with the trap enabled.
        run_inst(8'h02, 8'hFF, 8'hFF);

        // Watchdog: sequencer jumps to T6 during a 4-cycle instruction.
        drive_cycle(0, 8'hAD, 1'b0, 1'b0);
        @(negedge clk);
        check("wdog t0 next_sync", 32'(bus.next_sync), 32'd0);
        @(posedge clk);
        #1;
        bus.sync  = 1'b0;
        bus.cycle = '0;
        @(negedge clk);
        check("wdog next_sync", 32'(bus.next_sync), 32'd1);
        @(posedge clk);
        #1;
        idle_cycle();
        @(negedge clk);
        check("wdog illegal", 32'(bus.illegal), 32'd1);
        @(posedge clk);
        #1;
        run_inst(8'hEA, 8'h00, 8'h00);

        // Reset in T3 of JSR.
        for (int t = 0; t < 4; t++) begin
            drive_cycle(t, 8'h20, 1'b0, 1'b0);
            if (t == 3) rst_n = 1'b0;
            @(negedge clk);
            check($sformatf("jsr next_sync t=%0d", t), 32'(bus.next_sync), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle_cycle();
        @(negedge clk);
        check("mid-reset next_sync", 32'(bus.next_sync), 32'd1);
        check("mid-reset ir", 32'(bus.ir), 32'h0EA);
        check("mid-reset illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;

        // Random instruction stream.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] op;
            logic [7:0] pcv;
            logic [7:0] btv;
            op  = 8'($urandom_range(0, 255));
            pcv = 8'($urandom);
            btv = 8'($urandom);
            run_inst(op, pcv, btv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
